adder_result_drain: RTL
=======================

// Module: adder_result_drain
// PURPOSE
//  Downstream companion of the 32-bit pipelined adder. Tracks which adder issue slots carried real operands.
//  Captures the matching {co,s} results into a DEPTH-entry FIFO and presents them on a valid/ready output.
//  Issues credit-based backpressure upstream, so in-flight plus stored results never exceed DEPTH.
//  The adder has no stall and no reset; this block alone decides which adder outputs are real.
// PARAMETERS
//  LATENCY  5   clock edges from the edge sampling a/b/ci into the adder to the edge capturing its s/co here
//  DEPTH    8   result FIFO entries; power of two, >= 2
//  WIDTH    32  adder sum width
// PORTS
//  clk          in   1          system clock, rising edge
//  rst          in   1          asynchronous, active-high reset
//  issue_valid  in   1          upstream drives a/b/ci to the adder this cycle with real operands
//  issue_ready  out  1          credit available; issue fires at an edge when issue_valid & issue_ready
//  adder_s      in   WIDTH      adder sum output
//  adder_co     in   1          adder carry-out output
//  out_valid    out  1          head result available
//  out_ready    in   1          consumer accepts head; pop fires when out_valid & out_ready
//  out_sum      out  WIDTH      head result sum
//  out_co       out  1          head result carry
//  occupancy    out  log2(DEPTH)+1  in-flight + stored results
//  err_ovf      out  1          sticky: capture attempted with FIFO full (must never assert in legal use)
// BEHAVIOUR
//  Reset (async, rst=1), all cleared immediately:
//   - valid pipe cleared; FIFO pointers, count and occupancy = 0
//   - out_valid=0, out_sum=0, out_co=0, err_ovf=0, issue_ready=1 once rst deasserts
//   - results in flight at reset are discarded; the adder's own unreset pipeline content is ignored
//  Valid pipe:
//   - LATENCY-stage shift register; stage 0 loads issue fire every edge; shifts unconditionally
//   - capture strobe = last stage; at an edge E it is 1 iff issue fired at edge E-LATENCY
//   - on capture, {adder_co, adder_s} are written to FIFO at wptr
//   - back-to-back issues produce back-to-back captures with no gaps or reordering
//  FIFO:
//   - out_valid = (count != 0); out_sum/out_co driven from mem[rptr] (registered storage, no input bypass)
//   - pointers wrap modulo DEPTH
//   - simultaneous capture and pop: count unchanged, both pointers advance
//   - result becomes visible on out_* the cycle after the capture edge, i.e. LATENCY+1 cycles after issue
//   - capture with count==DEPTH and no pop: entry dropped, err_ovf set until reset
//  Credit / occupancy:
//   - occupancy +1 on issue fire, -1 on pop, unchanged when both occur
//   - issue_ready = (occupancy < DEPTH); derived from registered state only (no comb path from out_ready)
//   - pop in the same cycle does not raise issue_ready until the next cycle
//  Widths: occupancy range 0..DEPTH inclusive; count range 0..DEPTH; no saturation arithmetic needed
//   because the credit rule bounds both counters
// TESTING
//  1. rst pulse mid-cycle, no clock edge -> all outputs zero immediately; issue_ready=1 after release
//  2. Single issue a=32'hFFFF_FFFF, b=1, ci=0, out_ready=1 -> out_valid high exactly LATENCY+1 cycles
//     later; out_sum=0, out_co=1; held for one cycle
//  3. 20 back-to-back issues of a=i, b=2*i, ci=i[0], out_ready=1 -> 20 consecutive results
//     sum=3i+i[0], co=0, in order
//  4. out_ready=0, issue continuously -> issue_ready drops after exactly DEPTH(8) fires;
//     occupancy=8; no err_ovf; release out_ready -> 8 correct results
//  5. FIFO full with out_ready toggling 1/0 while issuing -> occupancy never exceeds 8;
//     pointer wrap checked over 3 full rotations; order preserved
//  6. rst asserted with 3 results in flight and 2 stored -> after release, no spurious out_valid
//     for 2*LATENCY cycles; next issue returns correct sum

Source files
------------

// File: rtl/adder_result_drain_if.sv
// Handshake bundle between the adder issue logic, the adder outputs and the
// result consumer around adder_result_drain.
interface adder_result_drain_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
);
    logic                     issue_valid;
    logic                     issue_ready;
    logic [WIDTH-1:0]         adder_s;
    logic                     adder_co;
    logic                     out_valid;
    logic                     out_ready;
    logic [WIDTH-1:0]         out_sum;
    logic                     out_co;
    logic [$clog2(DEPTH):0]   occupancy;
    logic                     err_ovf;

    modport master (
        output issue_valid, adder_s, adder_co, out_ready,
        input  issue_ready, out_valid, out_sum, out_co, occupancy, err_ovf
    );

    modport slave (
        input  issue_valid, adder_s, adder_co, out_ready,
        output issue_ready, out_valid, out_sum, out_co, occupancy, err_ovf
    );
endinterface

// File: rtl/adder_result_drain.sv
// Captures results of the unstalled 32-bit pipelined adder for issue slots that
// carried real operands, buffers them in a FIFO and grants credits upstream.
module adder_result_drain #(
    parameter int LATENCY = 5,
    parameter int DEPTH   = 8,
    parameter int WIDTH   = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    adder_result_drain_if.slave  bus
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [LATENCY-1:0] vpipe_q, vpipe_d;
    logic [AW-1:0]      wptr_q, wptr_d;
    logic [AW-1:0]      rptr_q, rptr_d;
    logic [CW-1:0]      count_q, count_d;
    logic [CW-1:0]      occ_q, occ_d;
    logic               err_ovf_q, err_ovf_d;
    logic [WIDTH:0]     mem_q [DEPTH];

    logic issue_ready;
    logic issue_fire;
    logic capture;
    logic out_valid;
    logic pop;
    logic full;
    logic wr_en;

    // Credits come from registered occupancy only, so out_ready never reaches issue_ready.
    assign issue_ready = (occ_q < DEPTH_C);
    assign issue_fire  = bus.issue_valid & issue_ready;
    assign capture     = vpipe_q[LATENCY-1];
    assign out_valid   = (count_q != '0);
    assign pop         = out_valid & bus.out_ready;
    assign full        = (count_q == DEPTH_C);
    assign wr_en       = capture & (~full | pop);

    always_comb begin
        // NOTE: every signal gets a default first so no path through this block infers a latch.
        vpipe_d    = vpipe_q << 1;
        vpipe_d[0] = issue_fire;
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        err_ovf_d  = err_ovf_q;

        if (wr_en) wptr_d = wptr_q + AW'(1);
        if (pop)   rptr_d = rptr_q + AW'(1);
        if (capture & full & ~pop) err_ovf_d = 1'b1;

        count_d = count_q + CW'(wr_en) - CW'(pop);
        occ_d   = occ_q + CW'(issue_fire) - CW'(pop);
    end

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: state uses non-blocking assignments so all registers update from pre-edge values.
        if (rst) begin
            vpipe_q   <= '0;
            wptr_q    <= '0;
            rptr_q    <= '0;
            count_q   <= '0;
            occ_q     <= '0;
            err_ovf_q <= 1'b0;
        end else begin
            vpipe_q   <= vpipe_d;
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            count_q   <= count_d;
            occ_q     <= occ_d;
            err_ovf_q <= err_ovf_d;
        end
    end

    // NOTE: storage is deliberately not reset; count_q decides which entries are meaningful.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wptr_q] <= {bus.adder_co, bus.adder_s};
    end

    assign bus.issue_ready = issue_ready;
    assign bus.out_valid   = out_valid;
    assign bus.out_sum     = out_valid ? mem_q[rptr_q][WIDTH-1:0] : '0;
    assign bus.out_co      = out_valid & mem_q[rptr_q][WIDTH];
    assign bus.occupancy   = occ_q;
    assign bus.err_ovf     = err_ovf_q;

endmodule
